// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: elastic chain of DEPTH enabled register stages with per-stage
// valid bits and a combinational valid/allowin handshake. Bubbles absorb new
// data under backpressure; flush drops everything in flight.
module pipe_reg_chain #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] data_en;

    logic [DEPTH:0]   allow;
    logic [DEPTH-1:0] src_valid;
    logic [WIDTH-1:0] src_data [DEPTH];

    // Allowin ripples back from the output: a stage can take data if it is
    // empty or if the stage ahead of it can take its current contents.
    always_comb begin
        allow = '0;
        allow[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            allow[k] = !valid_q[k] || allow[k+1];
        end
    end

    // Each stage is fed by its predecessor; stage 0 is fed by the input port.
    always_comb begin
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            src_valid[k] = valid_q[k-1];
            src_data[k]  = data_q[k-1];
        end
    end

    // Next-state: flush clears valids and freezes data; otherwise advance
    // wherever allowin is set. Data only loads when a valid item arrives.
    always_comb begin
        valid_d = valid_q;
        data_en = '0;
        for (int k = 0; k < DEPTH; k++) begin
            data_d[k] = src_data[k];
        end
        if (flush) begin
            valid_d = '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (allow[k]) begin
                    valid_d[k] = src_valid[k];
                    data_en[k] = src_valid[k];
                end
            end
        end
    end

    // Stage registers with synchronous active-low reset; data is enable-gated.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= RESET_VAL;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < DEPTH; k++) begin
                if (data_en[k]) begin
                    data_q[k] <= data_d[k];
                end
            end
        end
    end

    // Occupancy is a popcount of the valid registers.
    always_comb begin
        count = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count = count + CW'(valid_q[k]);
        end
    end

    // Handshake outputs; input is refused during a flush cycle.
    always_comb begin
        in_ready  = allow[0] && !flush;
        out_valid = valid_q[DEPTH-1];
        out_data  = data_q[DEPTH-1];
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain (WIDTH=32, DEPTH=4). Inputs change on the
// falling edge; outputs are sampled on the falling edge or shortly after.
module tb_pipe_reg_chain;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             resetn;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    pipe_reg_chain #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL ({WIDTH{1'b0}})
    ) u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cnt;
        int acc;
        int gone;

        // Reset held 3 cycles with input offered.
        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hFFFF_FFFF;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_out_data", out_data, 32'h0);
        resetn   = 1'b1;
        in_valid = 1'b0;
        #1;
        check_eq("rst_in_ready_or0", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        #1;
        check_eq("rst_in_ready_or1", 32'(in_ready), 32'd1);

        // Streaming 1..8 with out_ready high.
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'd1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            acc     = (c < 8) ? c : 8;
            gone    = (c > 4) ? c - 4 : 0;
            exp_cnt = acc - gone;
            check_eq("stream_count", 32'(count), 32'(exp_cnt));
            check_eq("stream_out_valid", 32'(out_valid), (c >= 4 && c <= 11) ? 32'd1 : 32'd0);
            if (c >= 4 && c <= 11) begin
                check_eq("stream_out_data", out_data, 32'(c - 3));
            end
            in_valid = (c + 1 <= 8);
            in_data  = 32'(c + 1);
        end
        in_valid = 1'b0;

        // Backpressure: 6 offered, 4 accepted, then drain in order.
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'(k);
            #1;
            check_eq("bp_in_ready", 32'(in_ready), (k <= 4) ? 32'd1 : 32'd0);
        end
        check_eq("bp_count", 32'(count), 32'd4);
        check_eq("bp_out_data_head", out_data, 32'd1);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            check_eq("bp_drain_valid", 32'(out_valid), 32'd1);
            check_eq("bp_drain_data", out_data, 32'(j));
        end
        @(negedge clk);
        check_eq("bp_empty_count", 32'(count), 32'd0);
        check_eq("bp_empty_valid", 32'(out_valid), 32'd0);

        // Bubble: A, two idle cycles, B, with downstream stalled.
        do_reset();
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'hAA;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'hBB;
        #1;
        check_eq("bub_in_ready_b", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("bub_count", 32'(count), 32'd2);
        check_eq("bub_a_at_out_valid", 32'(out_valid), 32'd1);
        check_eq("bub_a_at_out_data", out_data, 32'hAA);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check_eq("bub_in_ready_hold", 32'(in_ready), 32'd1);
            check_eq("bub_count_hold", 32'(count), 32'd2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        // B must have packed into stage 2 to be visible one edge after A leaves.
        check_eq("bub_b_packed_valid", 32'(out_valid), 32'd1);
        check_eq("bub_b_packed_data", out_data, 32'hBB);
        check_eq("bub_b_count", 32'(count), 32'd1);

        // Flush with three items in flight and an input offered.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'(32'h11 + k);
        end
        @(negedge clk);
        check_eq("fl_count_pre", 32'(count), 32'd3);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hEE;
        #1;
        check_eq("fl_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("fl_count_post", 32'(count), 32'd0);
        check_eq("fl_out_valid_post", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check_eq("fl_no_output", 32'(out_valid), 32'd0);
        end

        // Full with simultaneous in/out for 10 cycles.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'(32'h21 + k);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("full_count_pre", 32'(count), 32'd4);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            in_valid  = 1'b1;
            in_data   = 32'(32'h31 + i);
            out_ready = 1'b1;
            #1;
            check_eq("full_in_ready", 32'(in_ready), 32'd1);
            check_eq("full_count", 32'(count), 32'd4);
            check_eq("full_out_valid", 32'(out_valid), 32'd1);
            check_eq("full_out_data", out_data,
                     (i < 4) ? 32'(32'h21 + i) : 32'(32'h31 + i - 4));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("full_count_post", 32'(count), 32'd4);
        check_eq("full_out_data_post", out_data, 32'h37);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
